// File: rtl/ahb_arbiter_rr.sv
// AHB arbiter for NUM_MASTERS masters: round-robin or fixed-priority selection,
// grant hold across fixed-length bursts and locked transfers, registered owner pipeline.
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int PRIORITY_MODE  = 0,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = 4
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);
  localparam logic [1:0] TR_IDLE    = 2'd0;
  localparam logic [1:0] TR_BUSY    = 2'd1;
  localparam logic [1:0] TR_NONSEQ  = 2'd2;
  localparam logic [1:0] TR_SEQ     = 2'd3;
  localparam logic [1:0] RESP_ERROR = 2'd1;
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_MASTER = MW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          hmaster_data_q, hmaster_data_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [4:0]             beats_left_q, beats_left_d;
  logic [MW-1:0]          owner_idx_s;
  logic                   owner_lock_s;
  logic                   owner_req_s;
  logic [NUM_MASTERS-1:0] req_hi_s, req_lo_s, winner_s;
  int                     start_s;

  // Beats remaining after the NONSEQ of a fixed-length burst; undefined-length bursts hold nothing.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    logic [4:0] beats;
    case (burst)
      3'd2, 3'd3: beats = 5'd3;
      3'd4, 3'd5: beats = 5'd7;
      3'd6, 3'd7: beats = 5'd15;
      default:    beats = 5'd0;
    endcase
    return beats;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] lowest_one(input logic [NUM_MASTERS-1:0] v);
    logic [NUM_MASTERS-1:0] r;
    r = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Decode the current grant holder from the one-hot grant vector.
  always_comb begin
    owner_idx_s  = '0;
    owner_lock_s = |(hgrant_q & hlock);
    owner_req_s  = |(hgrant_q & hbusreq);
    for (int i = 0; i < NUM_MASTERS; i++) begin
      owner_idx_s = owner_idx_s | (hgrant_q[i] ? MW'(i) : '0);
    end
  end

  // Candidate winner; round-robin searches upward from hmaster+1 and falls back to the holder.
  always_comb begin
    start_s = int'(hmaster_q) + 1;
    if (start_s >= NUM_MASTERS) begin
      start_s = 0;
    end else begin
      start_s = start_s;
    end
    req_hi_s = '0;
    req_lo_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req_hi_s[i] = hbusreq[i] & ~hgrant_q[i] & (i >= start_s);
      req_lo_s[i] = hbusreq[i] & ~hgrant_q[i] & (i < start_s);
    end
    if (PRIORITY_MODE == 1) begin
      winner_s = (|hbusreq) ? lowest_one(hbusreq) : DEF_GRANT;
    end else if (|req_hi_s) begin
      winner_s = lowest_one(req_hi_s);
    end else if (|req_lo_s) begin
      winner_s = lowest_one(req_lo_s);
    end else if (owner_req_s) begin
      winner_s = hgrant_q;
    end else begin
      winner_s = DEF_GRANT;
    end
  end

  // Burst beat counter; an ERROR during a wait state abandons the burst.
  always_comb begin
    beats_left_d = beats_left_q;
    if (hready) begin
      case (htrans)
        TR_NONSEQ: beats_left_d = burst_beats(hburst);
        TR_SEQ:    beats_left_d = (beats_left_q == 5'd0) ? 5'd0 : beats_left_q - 5'd1;
        TR_BUSY:   beats_left_d = beats_left_q;
        TR_IDLE:   beats_left_d = 5'd0;
        default:   beats_left_d = beats_left_q;
      endcase
    end else if (hresp == RESP_ERROR) begin
      beats_left_d = 5'd0;
    end else begin
      beats_left_d = beats_left_q;
    end
  end

  // Grant and owner pipeline advance only on accepted edges; lock outranks burst-end handover.
  always_comb begin
    hgrant_d       = hgrant_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hmastlock_d    = hmastlock_q;
    if (hready) begin
      if (owner_lock_s) begin
        hgrant_d = hgrant_q;
      end else if (beats_left_d <= 5'd1) begin
        hgrant_d = winner_s;
      end else begin
        hgrant_d = hgrant_q;
      end
      hmaster_d      = owner_idx_s;
      hmastlock_d    = owner_lock_s;
      hmaster_data_d = hmaster_q;
    end else begin
      hgrant_d = hgrant_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant_q       <= DEF_GRANT;
      hmaster_q      <= DEF_MASTER;
      hmaster_data_q <= DEF_MASTER;
      hmastlock_q    <= 1'b0;
      beats_left_q   <= 5'd0;
    end else begin
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
      beats_left_q   <= beats_left_d;
    end
  end

  assign hgrant       = hgrant_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;
  assign hmastlock    = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Table-driven bench for ahb_arbiter_rr: three instances (round-robin/default 0,
// round-robin/default 2, fixed priority) share stimulus; each vector checks one of them.
module tb_ahb_arbiter_rr;
  localparam logic [1:0] IDLE = 2'd0, NSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [1:0] OK = 2'd0, ERR = 2'd1;
  localparam logic [2:0] SGL = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

  typedef struct {
    int         sel;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [1:0] resp;
    logic [3:0] g;
    logic [3:0] m;
    logic [3:0] md;
    logic       ml;
  } vec_t;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans, hresp;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] g_rr, m_rr, md_rr, g_d2, m_d2, md_d2, g_fx, m_fx, md_fx;
  logic       ml_rr, ml_d2, ml_fx;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   applied = 0;
  int   miscompares = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_rr #(.NUM_MASTERS(4), .PRIORITY_MODE(0), .DEFAULT_MASTER(0), .MW(4)) u_rr (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hresp(hresp), .hgrant(g_rr), .hmaster(m_rr),
    .hmaster_data(md_rr), .hmastlock(ml_rr));

  ahb_arbiter_rr #(.NUM_MASTERS(4), .PRIORITY_MODE(0), .DEFAULT_MASTER(2), .MW(4)) u_d2 (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hresp(hresp), .hgrant(g_d2), .hmaster(m_d2),
    .hmaster_data(md_d2), .hmastlock(ml_d2));

  ahb_arbiter_rr #(.NUM_MASTERS(4), .PRIORITY_MODE(1), .DEFAULT_MASTER(0), .MW(4)) u_fx (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hresp(hresp), .hgrant(g_fx), .hmaster(m_fx),
    .hmaster_data(md_fx), .hmastlock(ml_fx));

  function automatic void add(input int sel, input logic rst, input logic [3:0] req,
                              input logic [3:0] lock, input logic [1:0] trans,
                              input logic [2:0] burst, input logic rdy, input logic [1:0] resp,
                              input logic [3:0] g, input logic [3:0] m, input logic [3:0] md,
                              input logic ml);
    vec_t v;
    v.sel = sel; v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.burst = burst;
    v.rdy = rdy; v.resp = resp; v.g = g; v.m = m; v.md = md; v.ml = ml;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vector %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;
    logic [3:0] ag, am, amd;
    logic       aml;

    // Reset default, DEFAULT_MASTER=2, no requests
    add(1, 1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0100, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++)
      add(1, 1'b0, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0100, 4'd2, 4'd2, 1'b0);

    // Round-robin rotation, all requesting, SINGLE transfers
    add(0, 1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b1111, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0010, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b1111, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0100, 4'd1, 4'd0, 1'b0);
    add(0, 1'b0, 4'b1111, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b1000, 4'd2, 4'd1, 1'b0);
    add(0, 1'b0, 4'b1111, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0001, 4'd3, 4'd2, 1'b0);
    add(0, 1'b0, 4'b1111, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0010, 4'd0, 4'd3, 1'b0);

    // INCR4 by master 1 holds the grant until one beat remains
    add(0, 1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0010, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0010, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0010, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0010, 4'd1, 4'd0, 1'b0);
    add(0, 1'b0, 4'b1010, 4'b0000, NSEQ, INCR4, 1'b1, OK, 4'b0010, 4'd1, 4'd1, 1'b0);
    add(0, 1'b0, 4'b1000, 4'b0000, SEQ, INCR4, 1'b1, OK, 4'b0010, 4'd1, 4'd1, 1'b0);
    add(0, 1'b0, 4'b1000, 4'b0000, SEQ, INCR4, 1'b1, OK, 4'b1000, 4'd1, 4'd1, 1'b0);
    add(0, 1'b0, 4'b1000, 4'b0000, SEQ, INCR4, 1'b1, OK, 4'b1000, 4'd3, 4'd1, 1'b0);
    add(0, 1'b0, 4'b1000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b1000, 4'd3, 4'd3, 1'b0);

    // Lock by master 0 while master 2 requests
    add(0, 1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(0, 1'b0, 4'b0101, 4'b0001, NSEQ, SGL, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b1);
    add(0, 1'b0, 4'b0101, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0100, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0100, 4'd2, 4'd0, 1'b0);

    // Wait states mid-INCR8, then ERROR during a wait state
    add(0, 1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, NSEQ, INCR8, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      add(0, 1'b0, 4'b0101, 4'b0000, SEQ, INCR8, 1'b0, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      add(0, 1'b0, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OK, 4'b0100, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OK, 4'b0001, 4'd2, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, NSEQ, INCR8, 1'b1, OK, 4'b0001, 4'd0, 4'd2, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, SEQ, INCR8, 1'b0, ERR, 4'b0001, 4'd0, 4'd2, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OK, 4'b0100, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, IDLE, SGL, 1'b0, OK, 4'b0100, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0101, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd2, 4'd0, 1'b0);

    // Fixed priority: masters 3 and 1 request
    add(2, 1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(2, 1'b0, 4'b1010, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0010, 4'd0, 4'd0, 1'b0);
    add(2, 1'b0, 4'b1010, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0010, 4'd1, 4'd0, 1'b0);
    add(2, 1'b0, 4'b1010, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b0010, 4'd1, 4'd1, 1'b0);
    add(2, 1'b0, 4'b1000, 4'b0000, NSEQ, SGL, 1'b1, OK, 4'b1000, 4'd1, 4'd1, 1'b0);
    add(2, 1'b0, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd3, 4'd1, 1'b0);

    // NONSEQ reload mid-burst, then reset during a locked INCR16
    add(0, 1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0000, NSEQ, INCR4, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0000, SEQ, INCR4, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0000, NSEQ, INCR4, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0000, SEQ, INCR4, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0000, SEQ, INCR4, 1'b1, OK, 4'b0100, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0100, NSEQ, INCR16, 1'b1, OK, 4'b0100, 4'd2, 4'd0, 1'b1);
    add(0, 1'b1, 4'b0100, 4'b0100, SEQ, INCR16, 1'b1, OK, 4'b0001, 4'd0, 4'd0, 1'b0);
    add(0, 1'b0, 4'b0100, 4'b0000, SEQ, INCR16, 1'b1, OK, 4'b0100, 4'd0, 4'd0, 1'b0);

    hreset = 1'b1; hbusreq = 4'b0000; hlock = 4'b0000; htrans = IDLE;
    hburst = SGL; hready = 1'b1; hresp = OK;

    foreach (vecs[k]) begin
      v = vecs[k];
      @(negedge hclk);
      hreset = v.rst; hbusreq = v.req; hlock = v.lock; htrans = v.trans;
      hburst = v.burst; hready = v.rdy; hresp = v.resp;
      exp_q.push_back(v);
      applied++;
      @(posedge hclk);
      #1;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard vector %0d: got empty queue, expected one entry", k);
      end else begin
        e = exp_q.pop_front();
        case (e.sel)
          0: begin ag = g_rr; am = m_rr; amd = md_rr; aml = ml_rr; end
          1: begin ag = g_d2; am = m_d2; amd = md_d2; aml = ml_d2; end
          default: begin ag = g_fx; am = m_fx; amd = md_fx; aml = ml_fx; end
        endcase
        check("hgrant", k, ag, e.g);
        check("hmaster", k, am, e.m);
        check("hmaster_data", k, amd, e.md);
        check("hmastlock", k, {3'b000, aml}, {3'b000, e.ml});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
